// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ALU codes, branch funct3 encodings, default XLEN and branch condition helper
package riscv_pkg;
  localparam int XLEN_DEF = 64;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  function automatic logic branch_cond(input logic [2:0] f3, input logic r_zero, input logic r_one);
    case (f3)
      F3_BEQ, F3_BGE, F3_BGEU: branch_cond = r_zero;
      F3_BNE:                  branch_cond = !r_zero;
      F3_BLT, F3_BLTU:         branch_cond = r_one;
      default:                 branch_cond = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU (a, b, aluctl -> result); undefined codes yield 0
import riscv_pkg::*;
module alu_core #(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [3:0]      aluctl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);
  logic [SHW-1:0] sh;
  assign sh = b[SHW-1:0];
  always_comb begin
    result = '0;
    case (aluctl)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << sh;
      ALU_SRL:  result = a >> sh;
      ALU_SUB:  result = a - b;
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SRA:  result = $signed(a) >>> sh;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage (alu + branch resolve) feeding the EX/MEM register with valid/ready, backpressure and flush
import riscv_pkg::*;
module ex_stage #(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_aluctl,
  input  logic            in_is_branch,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [4:0]      in_rd,
  input  logic            in_regwrite,
  input  logic            in_memread,
  input  logic            in_memwrite,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_branch_taken,
  output logic [XLEN-1:0] out_branch_target,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_regwrite,
  output logic            out_memread,
  output logic            out_memwrite
);
  logic [XLEN-1:0] alu_r;
  logic accept, r_zero, taken;
  alu_core #(.XLEN(XLEN), .SHW(SHW)) u_alu (.aluctl(in_aluctl), .a(in_a), .b(in_b), .result(alu_r));
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign r_zero   = alu_r == '0;
  assign taken    = in_is_branch && branch_cond(in_funct3, r_zero, alu_r == {{(XLEN-1){1'b0}}, 1'b1});
  // out_zero is registered so that reset leaves every output at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      out_result        <= '0;
      out_zero          <= 1'b0;
      out_branch_taken  <= 1'b0;
      out_branch_target <= '0;
      out_store_data    <= '0;
      out_rd            <= '0;
      out_regwrite      <= 1'b0;
      out_memread       <= 1'b0;
      out_memwrite      <= 1'b0;
    end else begin
      if (accept) begin
        out_result        <= alu_r;
        out_zero          <= r_zero;
        out_branch_taken  <= taken;
        out_branch_target <= in_pc + in_imm;
        out_store_data    <= in_store_data;
        out_rd            <= in_rd;
        out_regwrite      <= in_regwrite;
        out_memread       <= in_memread;
        out_memwrite      <= in_memwrite;
      end
      if (flush) begin
        out_valid        <= 1'b0;
        out_branch_taken <= 1'b0;
        out_regwrite     <= 1'b0;
        out_memread      <= 1'b0;
        out_memwrite     <= 1'b0;
      end else if (accept) out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage (directed cases then randomized traffic)
module tb_ex_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready, in_is_branch = 1'b0;
  logic [3:0] in_aluctl = '0;
  logic [2:0] in_funct3 = '0;
  logic [63:0] in_a = '0, in_b = '0, in_pc = '0, in_imm = '0, in_store_data = '0;
  logic [4:0] in_rd = '0;
  logic in_regwrite = 1'b0, in_memread = 1'b0, in_memwrite = 1'b0;
  logic out_valid, out_ready = 1'b0, out_zero, out_branch_taken, out_regwrite, out_memread, out_memwrite;
  logic [63:0] out_result, out_branch_target, out_store_data;
  logic [4:0] out_rd;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {
    logic [63:0] result, target, store;
    logic [4:0] rd;
    logic zero, taken, rw, mr, mw;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [63:0] snap;
  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluctl(in_aluctl), .in_is_branch(in_is_branch), .in_funct3(in_funct3),
    .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_imm(in_imm), .in_store_data(in_store_data),
    .in_rd(in_rd), .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_branch_taken(out_branch_taken), .out_branch_target(out_branch_target),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_regwrite(out_regwrite),
    .out_memread(out_memread), .out_memwrite(out_memwrite)
  );
  always #5 clk = !clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t model();
    exp_t m;
    logic [63:0] r;
    logic [5:0] s;
    s = in_b[5:0];
    case (in_aluctl)
      4'd0: r = in_a & in_b;
      4'd1: r = in_a | in_b;
      4'd2: r = in_a + in_b;
      4'd3: r = in_a ^ in_b;
      4'd4: r = in_a << s;
      4'd5: r = in_a >> s;
      4'd6: r = in_a + ~in_b + 64'd1;
      4'd7: r = (in_a < in_b) ? 64'd1 : 64'd0;
      4'd8: r = ($signed(in_a) < $signed(in_b)) ? 64'd1 : 64'd0;
      4'd9: r = (in_a >> s) | (in_a[63] ? ~(~64'd0 >> s) : 64'd0);
      default: r = 64'd0;
    endcase
    m.result = r;
    m.zero = r == 64'd0;
    m.taken = in_is_branch && ((in_funct3 inside {3'b000, 3'b101, 3'b111} && r == 64'd0) ||
                               (in_funct3 == 3'b001 && r != 64'd0) ||
                               (in_funct3 inside {3'b100, 3'b110} && r == 64'd1));
    m.target = in_pc + in_imm;
    m.store = in_store_data;
    m.rd = in_rd;
    m.rw = in_regwrite;
    m.mr = in_memread;
    m.mw = in_memwrite;
    return m;
  endfunction
  task automatic step();
    exp_t x;
    @(negedge clk);
    if (out_valid && (out_ready || flush)) begin
      if (q.size() == 0) check("sb_underflow", 64'(out_valid), 64'd0);
      else begin
        x = q.pop_front();
        if (out_ready) begin
          check("result", out_result, x.result);
          check("zero", 64'(out_zero), 64'(x.zero));
          check("taken", 64'(out_branch_taken), 64'(x.taken));
          check("target", out_branch_target, x.target);
          check("store", out_store_data, x.store);
          check("ctl", {59'd0, out_rd}, {59'd0, x.rd});
          check("rw_mr_mw", {61'd0, out_regwrite, out_memread, out_memwrite}, {61'd0, x.rw, x.mr, x.mw});
        end
      end
    end
    if (in_valid && in_ready && !flush) q.push_back(model());
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b,
                      input logic br, input logic [2:0] f3, input logic [63:0] pc,
                      input logic [63:0] imm, input logic mw);
    in_valid = 1'b1;
    in_aluctl = ctl;
    in_a = a;
    in_b = b;
    in_is_branch = br;
    in_funct3 = f3;
    in_pc = pc;
    in_imm = imm;
    in_store_data = a ^ {b[31:0], b[63:32]};
    in_rd = 5'(a[4:0] + 5'(ctl));
    in_regwrite = !mw && !br;
    in_memread = 1'b0;
    in_memwrite = mw;
  endtask
  task automatic check_all_zero(input string tag);
    check(tag, {out_result | out_branch_target | out_store_data},
          64'd0);
    check(tag, {54'd0, out_valid, out_zero, out_branch_taken, out_rd, out_regwrite, out_memread, out_memwrite}, 64'd0);
  endtask
  initial begin
    #3;
    check_all_zero("reset_init");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    beat(4'b0010, 64'd5, 64'd7, 0, 3'b000, 64'h40, 64'h8, 0);
    step();
    check("add", out_result, 64'd12);
    beat(4'b0110, 64'd5, 64'd7, 0, 3'b000, 64'h44, 64'h8, 0);
    step();
    check("sub", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
    beat(4'b1001, 64'h8000_0000_0000_0000, 64'd4, 0, 3'b000, 64'h48, 64'h8, 0);
    step();
    check("sra", out_result, 64'hF800_0000_0000_0000);
    check("b2b_valid", 64'(out_valid), 64'd1);
    beat(4'b1000, '1, 64'd1, 0, 3'b000, 64'h4c, 64'h8, 0);
    step();
    check("slt", out_result, 64'd1);
    beat(4'b0111, '1, 64'd1, 0, 3'b000, 64'h50, 64'h8, 0);
    step();
    check("sltu", out_result, 64'd0);
    beat(4'b1000, '1, 64'd1, 1, 3'b100, 64'h100, -64'sd8, 0);
    step();
    check("blt_taken", 64'(out_branch_taken), 64'd1);
    check("blt_target", out_branch_target, 64'hF8);
    beat(4'b0111, '1, 64'd1, 1, 3'b110, 64'h100, -64'sd8, 0);
    step();
    check("bltu_taken", 64'(out_branch_taken), 64'd0);
    out_ready = 1'b0;
    beat(4'b0011, 64'hA5A5, 64'h0F0F, 0, 3'b000, 64'h200, 64'h10, 0);
    step();
    snap = out_result;
    beat(4'b0001, 64'h1200, 64'h0034, 0, 3'b000, 64'h204, 64'h10, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ready", 64'(in_ready), 64'd0);
      check("stall_hold", out_result, snap);
      check("stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    step();
    check("next_beat", out_result, 64'h1234);
    in_valid = 1'b0;
    step();
    beat(4'b0010, 64'h1000, 64'h8, 0, 3'b000, 64'h300, 64'h4, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_memwrite", 64'(out_memwrite), 64'd0);
    beat(4'b1100, 64'd5, 64'd9, 0, 3'b000, 64'h400, 64'h4, 0);
    step();
    check("undef_result", out_result, 64'd0);
    check("undef_zero", 64'(out_zero), 64'd1);
    beat(4'b0110, 64'd42, 64'd42, 1, 3'b000, 64'h404, 64'h20, 0);
    step();
    check("beq_taken", 64'(out_branch_taken), 64'd1);
    check("beq_zero", 64'(out_zero), 64'd1);
    out_ready = 1'b0;
    beat(4'b0001, 64'hFF, 64'h100, 1, 3'b001, 64'h500, 64'h40, 0);
    step();
    in_valid = 1'b0;
    step();
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("reset_midstall");
    q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("ready_after_midreset", 64'(in_ready), 64'd1);
    for (int i = 0; i < 300; i++) begin
      beat(4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom},
           ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom},
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom},
           {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 9) == 0;
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("sb_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
